// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked frame out, ack, wait for bus idle.
// Optional macro PS2_TX_ACK_CHECK_EN turns a device nack into a tx_error pulse.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       PS2_CLK_in,
  input  logic       PS2_DAT_in,
  output logic       clk_drive_low,
  output logic       dat_drive_low
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE} state_t;

  state_t          state, state_n;
  logic [2:0]      clk_sync;   // [1] is the synchronized level, [2] its previous value
  logic [1:0]      dat_sync;
  logic [7:0]      data_q, data_n;
  logic            parity_q, parity_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      bit_cnt, bit_n;
  logic            clk_low_q, clk_low_n, dat_low_q, dat_low_n;
  logic            done_q, done_n, error_q, error_n;
  logic            sync_clk, sync_dat, fall, timeout;

  assign sync_clk = clk_sync[1];
  assign sync_dat = dat_sync[1];
  assign fall     = clk_sync[2] & ~clk_sync[1];
  // One counter serves both the inhibit period and the post-release timeout.
  assign timeout  = (state inside {SEND, ACK, WAIT_IDLE}) && (cnt == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      clk_sync  <= 3'b111;
      dat_sync  <= 2'b11;
      data_q    <= '0;
      parity_q  <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_n;
      clk_sync  <= {clk_sync[1:0], PS2_CLK_in};
      dat_sync  <= {dat_sync[0], PS2_DAT_in};
      data_q    <= data_n;
      parity_q  <= parity_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      clk_low_q <= clk_low_n;
      dat_low_q <= dat_low_n;
      done_q    <= done_n;
      error_q   <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    data_n    = data_q;
    parity_n  = parity_q;
    cnt_n     = cnt;
    bit_n     = bit_cnt;
    clk_low_n = clk_low_q;
    dat_low_n = dat_low_q;
    done_n    = 1'b0;
    error_n   = 1'b0;
    if (timeout) begin
      state_n   = IDLE;
      clk_low_n = 1'b0;
      dat_low_n = 1'b0;
      error_n   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          clk_low_n = 1'b0;
          dat_low_n = 1'b0;
          if (tx_start && !tx_busy) begin
            data_n    = tx_data;
            parity_n  = ~^tx_data;
            cnt_n     = '0;
            clk_low_n = 1'b1;
            state_n   = INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            dat_low_n = 1'b1;
            state_n   = REQUEST;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        REQUEST: begin
          clk_low_n = 1'b0;
          cnt_n     = '0;
          bit_n     = '0;
          state_n   = SEND;
        end
        SEND: begin
          cnt_n = cnt + 1'b1;
          if (fall) begin
            bit_n = bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              dat_low_n = ~data_q[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              dat_low_n = ~parity_q;
            end else begin
              dat_low_n = 1'b0;
              state_n   = ACK;
            end
          end
        end
        ACK: begin
          cnt_n = cnt + 1'b1;
          if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
            if (sync_dat) begin
              error_n = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = WAIT_IDLE;
            end
`else
            state_n = WAIT_IDLE;
`endif
          end
        end
        WAIT_IDLE: begin
          cnt_n = cnt + 1'b1;
          if (sync_clk && sync_dat) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign tx_busy       = (state != IDLE) | done_q | error_q;
  assign tx_done       = done_q;
  assign tx_error      = error_q;
  assign clk_drive_low = clk_low_q;
  assign dat_drive_low = dat_low_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: open-drain bus with a clocking device model, table and random frames, corner sequences.
module tb_ps2_tx;
  localparam int INH = 40;
  localparam int TO  = 1500;
  localparam int H   = 8;
`ifdef PS2_TX_ACK_CHECK_EN
  localparam logic NACK_DONE = 1'b0;
`else
  localparam logic NACK_DONE = 1'b1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, clk_drive_low, dat_drive_low;
  logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic       PS2_CLK_in, PS2_DAT_in;

  assign PS2_CLK_in = ~(clk_drive_low | dev_clk_low);
  assign PS2_DAT_in = ~(dat_drive_low | dev_dat_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .PS2_CLK_in(PS2_CLK_in), .PS2_DAT_in(PS2_DAT_in),
    .clk_drive_low(clk_drive_low), .dat_drive_low(dat_drive_low)
  );

  always #10 clock = ~clock;

  int errors = 0, checks = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;

  always @(negedge clock) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
  end

  typedef struct {
    logic [7:0]  data;
    logic        ack_low;
    logic [10:0] exp_frame;   // {stop, parity, data, start}
    logic        exp_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  // Issue a start and follow the inhibit/request phases; returns at the clock-release cycle.
  task automatic start_req(input logic [7:0] d, output int inh, output logic got);
    int n = 0;
    got = 1'b0;
    inh = 0;
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    while (!got && n < INH + 20) begin
      if (clk_drive_low && !dat_drive_low) inh++;
      else if (clk_drive_low && dat_drive_low) got = 1'b1;
      if (!got) begin
        @(negedge clock);
        n++;
      end
    end
    if (got) @(negedge clock);
  endtask

  // Device clocks out up to 11 cycles, sampling the data line before each falling edge.
  task automatic clock_frame(input logic ack_low, input int abort_at, input logic second,
                             output logic [10:0] frame);
    frame = '0;
    repeat (5) @(negedge clock);
    for (int k = 1; k <= 11; k++) begin
      frame[k-1] = PS2_DAT_in;
      if (k == 11) dev_dat_low = ack_low;
      if (second && k == 5) begin
        tx_data  = 8'h11;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        @(negedge clock);
      end else begin
        repeat (2) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock);
      if (k == abort_at) return;
      dev_clk_low = 1'b0;
      if (k == 11) dev_dat_low = 1'b0;
      repeat (H) @(negedge clock);
    end
  endtask

  task automatic wait_not_busy(output logic ok);
    int n = 0;
    while (tx_busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    ok = !tx_busy;
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] d, input logic ack_low,
                          input logic [10:0] exp_frame, input logic exp_done, input logic second);
    int d0, e0, inh;
    logic got, ok;
    logic [10:0] fr;
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(d, inh, got);
    check({tag, "/request"}, got, 1);
    check({tag, "/inhibit_cycles"}, inh, INH);
    check({tag, "/release"}, {clk_drive_low, dat_drive_low}, 2'b01);
    clock_frame(ack_low, 0, second, fr);
    check({tag, "/frame"}, fr, exp_frame);
    wait_not_busy(ok);
    check({tag, "/idle"}, ok, 1);
    repeat (3) @(negedge clock);
    #2;
    check({tag, "/done_pulses"}, done_cnt - d0, exp_done ? 1 : 0);
    check({tag, "/error_pulses"}, err_cnt - e0, exp_done ? 0 : 1);
  endtask

  vec_t vecs[6];

  initial begin
    int d0, e0, n, inh;
    logic got, ok;
    logic [10:0] fr;
    logic [7:0] rd;
    logic ra;

    vecs[0] = '{8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1};
    vecs[1] = '{8'hF4, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b1};
    vecs[2] = '{8'h00, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, NACK_DONE};
    vecs[3] = '{8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1};
    vecs[4] = '{8'h55, 1'b1, {1'b1, 1'b1, 8'h55, 1'b0}, 1'b1};
    vecs[5] = '{8'h80, 1'b0, {1'b1, 1'b0, 8'h80, 1'b0}, NACK_DONE};

    repeat (4) @(negedge clock);
    check("reset_outputs", {tx_busy, tx_done, tx_error, clk_drive_low, dat_drive_low}, 5'b0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("post_reset_outputs", {tx_busy, tx_done, tx_error, clk_drive_low, dat_drive_low}, 5'b0);

    // Bus clocks while idle must not start anything.
    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clock);
    end
    #2;
    check("idle_edges", {tx_busy, clk_drive_low, dat_drive_low, 1'b0}, 4'b0);
    check("idle_edge_pulses", done_cnt + err_cnt, 0);

    for (int i = 0; i < 6; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack_low,
               vecs[i].exp_frame, vecs[i].exp_done, 1'b0);

    // Second start during a busy transfer is dropped.
    run_xfer("busy_ignore", 8'hED, 1'b1, model_frame(8'hED), 1'b1, 1'b1);

    // Device never clocks: timeout counted from the clock release.
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'hA5, inh, got);
    check("timeout/request", got, 1);
    n = 0;
    while (!tx_error && n < TO + 50) begin
      @(negedge clock);
      n++;
    end
    check("timeout/latency", n, TO);
    check("timeout/lines_released", {clk_drive_low, dat_drive_low}, 2'b00);
    wait_not_busy(ok);
    check("timeout/idle", ok, 1);
    repeat (3) @(negedge clock);
    #2;
    check("timeout/done_pulses", done_cnt - d0, 0);
    check("timeout/error_pulses", err_cnt - e0, 1);

    // Reset in the middle of SEND, then a clean transfer.
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'h00, inh, got);
    check("abort/request", got, 1);
    clock_frame(1'b1, 4, 1'b0, fr);
    check("abort/driving_before_reset", dat_drive_low, 1);
    reset = 1'b1;
    @(negedge clock);
    check("abort/lines_released", {tx_busy, clk_drive_low, dat_drive_low}, 3'b000);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    #2;
    check("abort/no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    run_xfer("after_reset", 8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = ($urandom_range(0, 3) != 0);
      run_xfer($sformatf("rnd%0d", i), rd, ra, model_frame(rd), ra ? 1'b1 : NACK_DONE, 1'b0);
    end

    check("done_error_exclusive", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
